data_ram_arbiter: RTL and testbench
===================================

Name: data_ram_arbiter

Overview:
- Two-master arbiter that shares the single-port data RAM between the CPU load/store port and a DMA/loader port.
- Sits between the CPU core's ram_* bus, a DMA engine and data_ram in the SoC top.
- Fixed priority to the CPU, with a starvation guard that forces a DMA slot after a configurable number of consecutive CPU wins.
- Handshake-based: each access gets one arbitration cycle and one serve cycle.

Parameters:
- ADDR_W, 32, address width of both masters and the RAM.
- DATA_W, 32, data width.
- MAX_CPU_BURST, 4, consecutive CPU grants allowed while a DMA request is pending before DMA is forced; range 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cpu_req_i  in  1  CPU access request; held with its signals until cpu_ack_o.
- cpu_we_i  in  1  CPU write enable.
- cpu_addr_i  in  ADDR_W  CPU address.
- cpu_sel_i  in  4  CPU byte select.
- cpu_wdata_i  in  DATA_W  CPU write data.
- cpu_rdata_o  out  DATA_W  CPU read data, valid when cpu_ack_o=1.
- cpu_ack_o  out  1  CPU access complete.
- cpu_stall_o  out  1  cpu_req_i & ~cpu_ack_o.
- dma_req_i  in  1  DMA request; held until dma_ack_o.
- dma_we_i  in  1  DMA write enable.
- dma_addr_i  in  ADDR_W  DMA address.
- dma_sel_i  in  4  DMA byte select.
- dma_wdata_i  in  DATA_W  DMA write data.
- dma_rdata_o  out  DATA_W  DMA read data, valid when dma_ack_o=1.
- dma_ack_o  out  1  DMA access complete.
- ram_ce_o  out  1  RAM chip enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_sel_o  out  4  RAM byte select.
- ram_data_o  out  DATA_W  RAM write data.
- ram_data_i  in  DATA_W  RAM read data (combinational read).

Behaviour:
- States: IDLE, SERVE_CPU, SERVE_DMA. The state register and the starvation counter cnt (8 bit) are the only registers.
- Reset: state=IDLE, cnt=0. In IDLE every output is 0: ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o, both acks and both rdata.
- cpu_stall_o follows cpu_req_i in IDLE, per its definition.
- Arbitration happens only in IDLE, at the clock edge:
  - cpu_req_i=1 and (dma_req_i=0 or cnt<MAX_CPU_BURST) -> SERVE_CPU. cnt increments if dma_req_i=1, otherwise cnt clears to 0.
  - dma_req_i=1 and (cpu_req_i=0 or cnt>=MAX_CPU_BURST) -> SERVE_DMA, cnt clears to 0.
  - No request -> stay in IDLE, cnt clears to 0.
- SERVE_x, one cycle:
  - RAM port is combinationally driven from master x's inputs, with ram_ce_o=1 and ram_we_o=x_we_i.
  - x_ack_o=1 and x_rdata_o=ram_data_i.
  - The other master's ack is 0 and its rdata is 0.
  - The write commits at the closing edge.
  - Next state is always IDLE.
- Latency: ack in the 2nd cycle after req is sampled in IDLE, i.e. 1 wait cycle. Peak throughput is one access per 2 cycles.
- Requesters deassert req or present a new access on the cycle after ack. A req still high in IDLE is a new access.
- Simultaneous requests: CPU wins unless cnt>=MAX_CPU_BURST. After MAX_CPU_BURST consecutive contended CPU wins, exactly one DMA access is granted, then the CPU regains priority.
- A request dropped before ack is a protocol violation. The arbiter still completes the serve cycle (RAM access occurs) but the result is unspecified for the master.
- Reset asserted mid-SERVE: the next edge forces IDLE, no ack follows, and ram_ce_o=0 from the first cycle after that edge.

Test Plan:
- Reset: rst=1 for 2 cycles with both reqs high -> all ram_* and ack outputs 0, state IDLE. Release -> CPU acked 2 cycles later.
- CPU write then read: write addr 0x10, sel 4'b1111, data 0xDEADBEEF -> ram_ce_o=ram_we_o=1 for one cycle, cpu_ack_o. Then read 0x10 -> cpu_rdata_o=0xDEADBEEF in the ack cycle, cpu_stall_o=1 only in the wait cycle.
- DMA alone: DMA write 0x20=0x12345678, sel 4'b0011 -> dma_ack_o after 1 wait cycle, RAM lower halfword updated, cpu_ack_o stays 0.
- Contention with MAX_CPU_BURST=4: both reqs held continuously -> grant order CPU,CPU,CPU,CPU,DMA,CPU,CPU,CPU,CPU,DMA; acks every 2nd cycle, never both in one cycle.
- Simultaneous single requests: both assert in the same IDLE cycle, cnt=0 -> CPU served first, then DMA, with dma_ack_o 4 cycles after the request.
- Reset mid-serve: assert rst during SERVE_DMA -> no further dma_ack_o after the edge, ram_ce_o=0, cnt=0. A fresh request afterwards is acked normally.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// Two-master arbiter sharing a single-port data RAM between the CPU and a DMA port.
// CPU has fixed priority; a starvation counter forces one DMA slot after MAX_CPU_BURST contended CPU wins.
module data_ram_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [3:0]        cpu_sel_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_ack_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [3:0]        dma_sel_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_ack_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_CPU = 2'd1,
        SERVE_DMA = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             burst_spent;

    // CPU has used up its contended burst allowance; DMA must win the next contest
    assign burst_spent = (cnt >= CNT_W'(MAX_CPU_BURST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = IDLE;
        cnt_nxt     = cnt;
        ram_ce_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_sel_o   = '0;
        ram_data_o  = '0;
        cpu_ack_o   = 1'b0;
        cpu_rdata_o = '0;
        dma_ack_o   = 1'b0;
        dma_rdata_o = '0;

        unique case (state)
            IDLE: begin
                if (cpu_req_i && (!dma_req_i || !burst_spent)) begin
                    state_nxt = SERVE_CPU;
                    cnt_nxt   = dma_req_i ? cnt + CNT_W'(1) : '0;
                end else if (dma_req_i) begin
                    state_nxt = SERVE_DMA;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = '0;
                end
            end
            SERVE_CPU: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = cpu_we_i;
                ram_addr_o  = cpu_addr_i;
                ram_sel_o   = cpu_sel_i;
                ram_data_o  = cpu_wdata_i;
                cpu_ack_o   = 1'b1;
                cpu_rdata_o = ram_data_i;
            end
            SERVE_DMA: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = dma_we_i;
                ram_addr_o  = dma_addr_i;
                ram_sel_o   = dma_sel_i;
                ram_data_o  = dma_wdata_i;
                dma_ack_o   = 1'b1;
                dma_rdata_o = ram_data_i;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: directed scenarios plus randomized traffic against a slot/priority model.
module tb_data_ram_arbiter;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_BURST = 4;
    localparam int          SL_NONE   = 0;
    localparam int          SL_CPU    = 1;
    localparam int          SL_DMA    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [3:0]        cpu_sel;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dma_req, dma_we, dma_ack;
    logic [ADDR_W-1:0] dma_addr;
    logic [3:0]        dma_sel;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic              ram_ce, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_sel;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    data_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_sel_i(cpu_sel),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_stall_o(cpu_stall),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_sel_i(dma_sel),
        .dma_wdata_i(dma_wdata), .dma_rdata_o(dma_rdata), .dma_ack_o(dma_ack),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_sel_o(ram_sel),
        .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
    );

    // 64-word RAM with byte-masked synchronous write and combinational read
    logic [31:0] mem [0:63];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end
    assign ram_rdata = mem[ram_addr[7:2]];

    task automatic go_idle(input int n);
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One access on one master; lat counts cycles from request cycle (1) to ack cycle
    task automatic access(input bit is_dma, input bit we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd);
        @(posedge clk); #1;
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_sel = sel; dma_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdata = wd;
        end
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (is_dma ? dma_ack : cpu_ack) begin
                lat = i;
                rd  = is_dma ? dma_rdata : cpu_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        if (is_dma) begin dma_req = 1'b0; dma_we = 1'b0; end
        else        begin cpu_req = 1'b0; cpu_we = 1'b0; end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_sel = 4'hF; cpu_wdata = 32'h1111_1111;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h44; dma_sel = 4'hF; dma_wdata = 32'h2222_2222;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, cpu_ack, dma_ack, cpu_rdata, dma_rdata} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: ce=%b we=%b addr=%h sel=%h wd=%h acks=%b%b expected all 0",
                         ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, cpu_ack, dma_ack);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cpu_ack, dma_ack} !== 2'b00) begin
            n_fail++; $display("FAIL reset_release_wait: acks=%b expected 00", {cpu_ack, dma_ack});
        end
        @(negedge clk);
        n_checks++;
        if ({cpu_ack, dma_ack} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release_cpu_ack: acks=%b expected 10", {cpu_ack, dma_ack});
        end
        go_idle(3);
    endtask

    task automatic test_cpu_write_read();
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_sel = 4'hF; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if ({cpu_stall, ram_ce, cpu_ack} !== 3'b100) begin
            n_fail++; $display("FAIL wr_wait_cycle: stall/ce/ack=%b expected 100", {cpu_stall, ram_ce, cpu_ack});
        end
        @(negedge clk);
        n_checks++;
        if ({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, cpu_ack, cpu_stall} !==
            {1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_serve_cycle: ce=%b we=%b addr=%h sel=%h wd=%h ack=%b stall=%b expected 1 1 10 f deadbeef 1 0",
                     ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, cpu_ack, cpu_stall);
        end
        @(posedge clk); #1;
        cpu_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cpu_stall, ram_ce, cpu_ack} !== 3'b100 || mem[4] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rd_wait_cycle: stall/ce/ack=%b mem=%h expected 100 deadbeef", {cpu_stall, ram_ce, cpu_ack}, mem[4]);
        end
        @(negedge clk);
        n_checks++;
        if ({cpu_ack, cpu_stall, ram_we, cpu_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL rd_serve_cycle: ack=%b stall=%b we=%b rdata=%h expected 1 0 0 deadbeef",
                     cpu_ack, cpu_stall, ram_we, cpu_rdata);
        end
        go_idle(3);
    endtask

    task automatic test_dma_alone();
        int          lat;
        logic [31:0] rd;
        access(1'b0, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, lat, rd);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL cpu_prefill_latency: got %0d expected 2", lat); end
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_sel = 4'b0011; dma_wdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if ({cpu_ack, dma_ack, ram_ce} !== 3'b000) begin
            n_fail++; $display("FAIL dma_wait_cycle: cpu_ack/dma_ack/ce=%b expected 000", {cpu_ack, dma_ack, ram_ce});
        end
        @(negedge clk);
        n_checks++;
        if ({cpu_ack, dma_ack, ram_ce, ram_we, ram_sel} !== {1'b0, 1'b1, 1'b1, 1'b1, 4'b0011}) begin
            n_fail++;
            $display("FAIL dma_serve_cycle: cpu_ack=%b dma_ack=%b ce=%b we=%b sel=%b expected 0 1 1 1 0011",
                     cpu_ack, dma_ack, ram_ce, ram_we, ram_sel);
        end
        @(posedge clk); #1;
        dma_req = 1'b0; dma_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem[8] !== 32'hCAFE_5678) begin
            n_fail++; $display("FAIL dma_halfword_write: mem=%h expected cafe5678", mem[8]);
        end
        access(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, lat, rd);
        n_checks++;
        if (lat !== 2 || rd !== 32'hCAFE_5678) begin
            n_fail++; $display("FAIL dma_readback: lat=%0d rdata=%h expected 2 cafe5678", lat, rd);
        end
        go_idle(3);
    endtask

    task automatic test_contention();
        int         streak = 0;
        logic [1:0] exp;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp = 2'b00;
            if (k % 2 == 0) begin
                if (streak >= int'(MAX_BURST)) begin exp = 2'b01; streak = 0; end
                else begin exp = 2'b10; streak++; end
            end
            n_checks++;
            if ({cpu_ack, dma_ack} !== exp) begin
                n_fail++; $display("FAIL contention_cycle_%0d: acks=%b expected %b", k, {cpu_ack, dma_ack}, exp);
            end
        end
        go_idle(3);
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp [4];
        exp[0] = 2'b00; exp[1] = 2'b10; exp[2] = 2'b00; exp[3] = 2'b01;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({cpu_ack, dma_ack} !== exp[k]) begin
                n_fail++; $display("FAIL simul_cycle_%0d: acks=%b expected %b", k + 1, {cpu_ack, dma_ack}, exp[k]);
            end
            if (k == 1) begin
                n_checks++;
                if (cpu_rdata !== 32'hDEAD_BEEF || dma_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL simul_cpu_rdata: cpu=%h dma=%h expected deadbeef 0", cpu_rdata, dma_rdata);
                end
                @(posedge clk); #1;
                cpu_req = 1'b0;
            end
            if (k == 3) begin
                n_checks++;
                if (dma_rdata !== 32'hCAFE_5678 || cpu_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL simul_dma_rdata: dma=%h cpu=%h expected cafe5678 0", dma_rdata, cpu_rdata);
                end
            end
        end
        go_idle(3);
    endtask

    task automatic test_reset_mid_serve();
        int         streak = 0;
        logic [1:0] exp;
        // reset lands while DMA is being served; the request stays high throughout
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dma_ack !== 1'b1) begin n_fail++; $display("FAIL rms_dma_served: dma_ack=%b expected 1", dma_ack); end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({dma_ack, cpu_ack, ram_ce} !== 3'b000) begin
                n_fail++; $display("FAIL rms_in_reset_%0d: dma_ack/cpu_ack/ce=%b expected 000", k, {dma_ack, cpu_ack, ram_ce});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dma_ack !== 1'b1) begin n_fail++; $display("FAIL rms_fresh_dma_ack: dma_ack=%b expected 1", dma_ack); end
        go_idle(3);
        // build up three contended CPU wins, then reset during the third CPU serve
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_addr = 32'h10; dma_req = 1'b1; dma_addr = 32'h20;
        for (int k = 1; k <= 6; k++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = 2'b00;
            if (k % 2 == 0) begin
                if (streak >= int'(MAX_BURST)) begin exp = 2'b01; streak = 0; end
                else begin exp = 2'b10; streak++; end
            end
            n_checks++;
            if ({cpu_ack, dma_ack} !== exp) begin
                n_fail++; $display("FAIL rms_cnt_cleared_cycle_%0d: acks=%b expected %b", k, {cpu_ack, dma_ack}, exp);
            end
        end
        go_idle(3);
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [0:63];
        int          slot = SL_NONE;
        int          streak = 0;
        bit          cpu_pend = 1'b0, dma_pend = 1'b0, cpu_done = 1'b0, dma_done = 1'b0;
        logic [31:0] exp_c, exp_d;
        bit          diff = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (cpu_done) cpu_pend = 1'b0;
            if (dma_done) dma_pend = 1'b0;
            if (!cpu_pend && $urandom_range(0, 1) == 1) begin
                cpu_pend = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                cpu_sel = 4'($urandom_range(1, 15)); cpu_wdata = $urandom;
            end
            if (!dma_pend && $urandom_range(0, 2) != 0) begin
                dma_pend = 1'b1; dma_we = 1'($urandom_range(0, 1));
                dma_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                dma_sel = 4'($urandom_range(1, 15)); dma_wdata = $urandom;
            end
            cpu_req = cpu_pend; dma_req = dma_pend;
            @(negedge clk);
            n_checks++;
            if ({cpu_ack, dma_ack} !== {slot == SL_CPU, slot == SL_DMA}) begin
                n_fail++; $display("FAIL rand_ack_%0d: acks=%b expected slot %0d", cyc, {cpu_ack, dma_ack}, slot);
            end
            exp_c = (slot == SL_CPU) ? ref_mem[cpu_addr[7:2]] : 32'h0;
            exp_d = (slot == SL_DMA) ? ref_mem[dma_addr[7:2]] : 32'h0;
            n_checks++;
            if (cpu_rdata !== exp_c || dma_rdata !== exp_d) begin
                n_fail++; $display("FAIL rand_rdata_%0d: cpu=%h dma=%h expected %h %h", cyc, cpu_rdata, dma_rdata, exp_c, exp_d);
            end
            n_checks++;
            if (cpu_stall !== (cpu_pend && slot != SL_CPU)) begin
                n_fail++; $display("FAIL rand_stall_%0d: stall=%b expected %b", cyc, cpu_stall, cpu_pend && slot != SL_CPU);
            end
            for (int b = 0; b < 4; b++) begin
                if (slot == SL_CPU && cpu_we && cpu_sel[b]) ref_mem[cpu_addr[7:2]][8*b +: 8] = cpu_wdata[8*b +: 8];
                if (slot == SL_DMA && dma_we && dma_sel[b]) ref_mem[dma_addr[7:2]][8*b +: 8] = dma_wdata[8*b +: 8];
            end
            cpu_done = (slot == SL_CPU);
            dma_done = (slot == SL_DMA);
            // every grant occupies the following cycle; a free cycle arbitrates by priority and burst budget
            if (slot != SL_NONE) begin
                slot = SL_NONE;
            end else if (cpu_pend && (!dma_pend || streak < int'(MAX_BURST))) begin
                slot = SL_CPU; streak = dma_pend ? streak + 1 : 0;
            end else if (dma_pend) begin
                slot = SL_DMA; streak = 0;
            end else begin
                streak = 0;
            end
        end
        go_idle(3);
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diff = 1'b1;
        n_checks++;
        if (diff) begin n_fail++; $display("FAIL rand_final_memory: RAM contents differ from reference image"); end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_dma_alone();
        test_contention();
        test_simultaneous();
        test_reset_mid_serve();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
